// File: rtl/updown_trace_decoder_pkg.sv
// Shared types for the up/down counter trace decoder: event kinds, FSM states
// and the queued event record.
package updown_trace_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EV_UP    = 2'd0,
    EV_DOWN  = 2'd1,
    EV_RESET = 2'd2,
    EV_ERR   = 2'd3
  } ev_kind_t;

  typedef enum logic {
    PRIME,
    TRACK
  } state_t;

  typedef struct packed {
    ev_kind_t                 kind;
    logic [DEFAULT_WIDTH-1:0] value;
  } trace_event_t;

endpackage

// File: rtl/updown_trace_decoder_if.sv
// Valid/ready event stream carrying decoded counter events out of the monitor.
interface updown_trace_decoder_if #(
  parameter int unsigned WIDTH = 32
);
  import updown_trace_pkg::*;

  logic             ev_valid;
  logic             ev_ready;
  ev_kind_t         ev_kind;
  logic [WIDTH-1:0] ev_value;

  modport master (
    output ev_valid,
    output ev_kind,
    output ev_value,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_kind,
    input  ev_value,
    output ev_ready
  );
endinterface

// File: rtl/updown_trace_decoder_fifo.sv
// Synchronous show-ahead FIFO; the caller guarantees push is only raised when
// there is room (or a pop happens in the same cycle).
module trace_event_fifo #(
  parameter int unsigned DATA_W = 34,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/updown_trace_decoder.sv
// Passive decoder for an up/down counter's output: reconstructs up/down/reset
// instructions from consecutive samples, queues events and keeps statistics.
module updown_trace_decoder
  import updown_trace_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       value,
  updown_trace_decoder_if.master ev,
  output logic                   overflow,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       up_cnt,
  output logic [CNT_W-1:0]       down_cnt,
  output logic [CNT_W-1:0]       rst_cnt,
  output logic [CNT_W-1:0]       err_cnt
);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  ev_kind_t         kind;

  logic             push;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             full;
  logic             empty;
  logic [WIDTH+1:0] head;

  // Priority order matters: a held reset (0 -> 0) beats everything, and
  // 1 -> 0 is decoded as DOWN before the generic "went to zero" RESET rule.
  always_comb begin
    delta = value - prev;
    kind  = EV_ERR;
    if (value == '0 && prev == '0) kind = EV_RESET;
    else if (delta == ONE)         kind = EV_UP;
    else if (delta == '1)          kind = EV_DOWN;
    else if (value == '0)          kind = EV_RESET;
  end

  assign push   = enable && (state == TRACK);
  assign pop    = !empty && ev.ev_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  trace_event_fifo #(
    .DATA_W (WIDTH + 2),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data ({kind, value}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign ev.ev_valid = !empty;
  assign ev.ev_kind  = empty ? EV_UP : ev_kind_t'(head[WIDTH+1:WIDTH]);
  assign ev.ev_value = empty ? '0 : head[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PRIME;
      prev     <= '0;
      overflow <= 1'b0;
      mismatch <= 1'b0;
      up_cnt   <= '0;
      down_cnt <= '0;
      rst_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (enable) begin
            prev  <= value;
            state <= TRACK;
          end
        end
        TRACK: begin
          if (enable) prev  <= value;
          else        state <= PRIME;
        end
        default: state <= PRIME;
      endcase

      if (drop) overflow <= 1'b1;

      // Statistics see every decoded event, whether or not the FIFO kept it.
      if (push) begin
        case (kind)
          EV_UP:    if (~&up_cnt)   up_cnt   <= up_cnt + CNT_ONE;
          EV_DOWN:  if (~&down_cnt) down_cnt <= down_cnt + CNT_ONE;
          EV_RESET: if (~&rst_cnt)  rst_cnt  <= rst_cnt + CNT_ONE;
          default: begin
            if (~&err_cnt) err_cnt <= err_cnt + CNT_ONE;
            mismatch <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_trace_decoder.sv
// Directed bench for updown_trace_decoder with a scoreboard of expected events.
module tb_updown_trace_decoder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] K_UP    = 2'd0;
  localparam logic [1:0] K_DOWN  = 2'd1;
  localparam logic [1:0] K_RESET = 2'd2;
  localparam logic [1:0] K_ERR   = 2'd3;

  typedef struct {
    logic [1:0]       k;
    logic [WIDTH-1:0] v;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] value;
  logic             overflow;
  logic             mismatch;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] down_cnt;
  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] err_cnt;

  updown_trace_decoder_if #(.WIDTH(WIDTH)) ev ();

  updown_trace_decoder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .value    (value),
    .ev       (ev),
    .overflow (overflow),
    .mismatch (mismatch),
    .up_cnt   (up_cnt),
    .down_cnt (down_cnt),
    .rst_cnt  (rst_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   primed;
  logic [WIDTH-1:0] mprev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] v);
    if (p == 32'd0 && v == 32'd0)          return K_RESET;
    if (v == p + 32'd1)                    return K_UP;
    if (p == v + 32'd1)                    return K_DOWN;
    if (v == 32'd0)                        return K_RESET;
    return K_ERR;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; value = '0; ev.ev_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    exp_q.delete();
    primed = 1'b0;
    check("rst_valid",    64'(ev.ev_valid), 64'd0);
    check("rst_kind",     64'(ev.ev_kind),  64'd0);
    check("rst_value",    64'(ev.ev_value), 64'd0);
    check("rst_overflow", 64'(overflow),    64'd0);
    check("rst_mismatch", 64'(mismatch),    64'd0);
    check("rst_counts",   {up_cnt, down_cnt, rst_cnt, err_cnt}, 64'd0);
  endtask

  // One clock: drive inputs, check head against the scoreboard, advance model.
  task automatic step(input logic en, input logic [WIDTH-1:0] val, input logic rdy);
    exp_t e;
    @(negedge clock);
    enable = en; value = val; ev.ev_ready = rdy;
    #1;
    check("ev_valid", 64'(ev.ev_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("ev_kind",  64'(ev.ev_kind),  64'(exp_q[0].k));
      check("ev_value", 64'(ev.ev_value), 64'(exp_q[0].v));
      if (rdy) void'(exp_q.pop_front());
    end
    if (!en) begin
      primed = 1'b0;
    end else if (!primed) begin
      primed = 1'b1;
      mprev  = val;
    end else begin
      e.k = classify(mprev, val);
      e.v = val;
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      mprev = val;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; value = '0; ev.ev_ready = 1'b0;
    primed = 1'b0; mprev = '0;

    // Count-up
    do_reset();
    step(1'b1, 32'd5, 1'b1);
    step(1'b1, 32'd6, 1'b1);
    step(1'b1, 32'd7, 1'b1);
    step(1'b1, 32'd8, 1'b1);
    drain(3);
    check("countup_up_cnt",   64'(up_cnt),   64'd3);
    check("countup_mismatch", 64'(mismatch), 64'd0);
    check("countup_empty",    64'(ev.ev_valid), 64'd0);

    // Wrap both ways
    do_reset();
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 32'h0,         1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    drain(3);
    check("wrap_up_cnt",   64'(up_cnt),   64'd1);
    check("wrap_down_cnt", 64'(down_cnt), 64'd1);

    // Reset decode, then 1 -> 0 is DOWN
    do_reset();
    step(1'b1, 32'h10, 1'b1);
    step(1'b1, 32'h0,  1'b1);
    step(1'b1, 32'h0,  1'b1);
    step(1'b0, 32'h0,  1'b1);
    check("rstdec_rst_cnt", 64'(rst_cnt), 64'd2);
    step(1'b1, 32'd1, 1'b1);
    step(1'b1, 32'd0, 1'b1);
    drain(3);
    check("rstdec_rst_cnt2",  64'(rst_cnt),  64'd2);
    check("rstdec_down_cnt",  64'(down_cnt), 64'd1);

    // Jump error, sticky mismatch
    do_reset();
    step(1'b1, 32'd3, 1'b1);
    step(1'b1, 32'd7, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    check("jump_mismatch", 64'(mismatch), 64'd1);
    check("jump_err_cnt",  64'(err_cnt),  64'd1);
    step(1'b1, 32'd8, 1'b1);
    step(1'b1, 32'd9, 1'b1);
    step(1'b1, 32'd10, 1'b1);
    drain(3);
    check("jump_mismatch_sticky", 64'(mismatch), 64'd1);
    check("jump_up_cnt",          64'(up_cnt),   64'd2);

    // Backpressure / overflow: prime 20, ten UPs 21..30, keep 21..28
    do_reset();
    step(1'b1, 32'd20, 1'b0);
    for (int i = 21; i <= 30; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_up_cnt",   64'(up_cnt),   64'd10);
    check("ovf_queued",   64'(exp_q.size()), 64'(DEPTH));
    drain(DEPTH);
    step(1'b0, 32'd0, 1'b0);
    check("ovf_drained", 64'(ev.ev_valid), 64'd0);

    // Push and pop together while full: no drop
    do_reset();
    step(1'b1, 32'd40, 1'b0);
    for (int i = 41; i <= 48; i++) step(1'b1, 32'(i), 1'b0);
    check("full_no_ovf", 64'(overflow), 64'd0);
    step(1'b1, 32'd49, 1'b1);
    drain(DEPTH + 1);
    check("pushpop_no_ovf", 64'(overflow), 64'd0);
    check("pushpop_up_cnt", 64'(up_cnt),   64'd9);
    check("pushpop_empty",  64'(ev.ev_valid), 64'd0);

    // Enable gap: no event across the gap or at the re-prime sample
    do_reset();
    step(1'b1, 32'd4,   1'b1);
    step(1'b1, 32'd5,   1'b1);
    step(1'b0, 32'd100, 1'b1);
    step(1'b0, 32'd100, 1'b1);
    step(1'b1, 32'd100, 1'b1);
    step(1'b1, 32'd101, 1'b1);
    drain(3);
    check("gap_err_cnt", 64'(err_cnt), 64'd0);
    check("gap_up_cnt",  64'(up_cnt),  64'd2);

    // Reset mid-operation discards queued events
    step(1'b1, 32'd60, 1'b0);
    step(1'b1, 32'd61, 1'b0);
    step(1'b1, 32'd62, 1'b0);
    do_reset();
    step(1'b0, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_trace_decoder.md
# updown_trace_decoder

Passive monitor on the 32-bit output of an up/down counter: samples the counter value every clock, reconstructs the instruction stream that produced it (up, down, counter reset), and flags transitions no legal instruction can produce. Decoded events go into a small FIFO drained over a valid/ready interface. Saturating per-kind statistics are kept alongside. The block is the decoder end of the counter's 1-bit instruction interface; it sits beside the counter in benches and debug builds.

## Interface
- `WIDTH`, 32: counter value width.
- `DEPTH`, 8: event FIFO depth, power of two, ≥2.
- `CNT_W`, 16: width of each statistics counter.

- `clock` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: sample `value` this cycle.
- `value` input `WIDTH`: monitored counter output, registered upstream.
- `ev_valid` output 1: FIFO head holds an event.
- `ev_ready` input 1: consumer accepts the head this cycle.
- `ev_kind` output 2: head event kind.
- `ev_value` output `WIDTH`: counter value sampled with the head event.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.
- `mismatch` output 1: sticky; an `EV_ERR` was decoded.
- `up_cnt` output `CNT_W`: saturating count of UP events.
- `down_cnt` output `CNT_W`: saturating count of DOWN events.
- `rst_cnt` output `CNT_W`: saturating count of RESET events.
- `err_cnt` output `CNT_W`: saturating count of ERR events.

## Operation
- FSM states:
  - `PRIME`: entered on `reset` and when `enable` is low. With `enable` high, latches `value` into `prev` and moves to `TRACK`. Emits no event.
  - `TRACK`: each enabled cycle compares `value` with `prev`, classifies the pair, pushes one event, and updates `prev`. If `enable` is low, returns to `PRIME` with no event.
- Classification, with delta = `value − prev` mod 2^`WIDTH`, first match wins:
  1. `value`==0 and `prev`==0 → `EV_RESET` (counter held in reset).
  2. delta==1 → `EV_UP`. Includes the wrap from all-ones to 0.
  3. delta==all-ones → `EV_DOWN`. Includes the wrap from 0 to all-ones, and 1→0. A reset from value 1 is indistinguishable from a down-count and is decoded as DOWN.
  4. `value`==0 → `EV_RESET`.
  5. Anything else → `EV_ERR`.
- Event kind encoding: UP=0, DOWN=1, RESET=2, ERR=3.
- Statistics:
  - The matching statistics counter increments on every decoded event, including events dropped by the FIFO.
  - Each counter saturates at all-ones.
  - `mismatch` sets on any ERR.
- FIFO:
  - Show-ahead.
  - A push when full drops the new event and sets `overflow`.
  - Push and pop in the same cycle when full are both accepted; no drop.
  - Pop occurs when `ev_valid && ev_ready`.
  - `ev_kind` and `ev_value` are stable while `ev_valid` is high and `ev_ready` is low.
- Reset values:
  - `ev_valid`, `overflow`, `mismatch`: 0.
  - All statistics counters: 0.
  - `ev_kind`=0, `ev_value`=0.
  - FIFO emptied; FSM in `PRIME`.
- Reset mid-operation discards all queued events. The first event after reset needs two enabled samples.

## Timing
- Cycle n is the first enabled sample in `PRIME`; it is latched into `prev`.
- Cycle n+1 is a `TRACK` sample: its event is pushed at the edge ending n+1 and `ev_valid` is high in cycle n+2. Decode-to-visible latency is 1 cycle.
- Statistics counters and sticky flags update at the same edge as the push.
- Sustained throughput is one event per cycle when `ev_ready` is held high.
- `ev_ready` is ignored while `ev_valid` is low.

## Structure
- Package `updown_trace_pkg` holds:
  - `ev_kind_t` (2-bit enum, encoding above);
  - state enum `PRIME`/`TRACK`;
  - the event record type `{ev_kind_t kind; logic [WIDTH-1:0] value}` for the default `WIDTH`.
- Sub-module `trace_event_fifo`: parameterised synchronous show-ahead FIFO with `full`/`empty`, simultaneous push/pop, and no internal drop logic.
- Drop detection, statistics and the FSM live in the top.

## Test plan
- **Count-up:** after reset, `enable`=1, `value` = 5,6,7,8 with `ev_ready`=1 → three UP events carrying values 6,7,8; `up_cnt`=3; `mismatch`=0.
- **Wrap both ways:** `value` = 0xFFFFFFFF,0x0,0xFFFFFFFF → UP(0x0), then DOWN(0xFFFFFFFF).
- **Reset decode:**
  - `value` = 0x10,0x0,0x0 → RESET, RESET; `rst_cnt`=2.
  - `value` = 1,0 → DOWN, not RESET.
- **Jump error:** `value` = 3,7 → ERR(7); `mismatch`=1 and stays 1 through later legal events until `reset`.
- **Backpressure/overflow:** `DEPTH`=8, `ev_ready`=0, ten consecutive UP transitions → 8 queued; `overflow`=1; `up_cnt`=10. Then `ev_ready`=1 drains 8 events in order, with values equal to the first eight samples after the prime sample.
- **Enable gap:** `value` 4,5, then `enable`=0 for two cycles while `value` jumps to 100, then `enable`=1 with `value` 100,101 → UP(5), no event at the gap or at 100, then UP(101); `err_cnt`=0.
